// File: rtl/console_uart_tx.sv
// Console byte sink: buffers SoC console bytes in a small FIFO and serialises
// them onto an 8N1 UART TX line. No back-pressure; bytes arriving when full are dropped.
//
// state  | meaning
// IDLE   | line high, pop head of FIFO when non-empty
// START  | start bit (low)
// DATA   | 8 data bits, LSB first
// STOP   | stop bit (high), then back to IDLE
module console_uart_tx #(
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [10:0]              in_byte,
    input  logic                     in_byte_en,
    input  logic                     clr_ovf,
    output logic                     tx,
    output logic                     busy,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [1:0]    r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_sh;
    logic          r_tx;
    logic          r_ovf;

    logic w_push;
    logic w_drop;
    logic w_pop;
    logic w_baud_end;
    logic w_unused_hi;

    // Fullness is judged on the occupancy before this cycle's pop.
    assign w_push      = in_byte_en && (r_count != FULL);
    assign w_drop      = in_byte_en && (r_count == FULL);
    assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
    assign w_baud_end  = (r_baud == BAUD_LAST);
    assign w_unused_hi = ^in_byte[10:8];

    assign tx         = r_tx;
    assign busy       = (r_state != S_IDLE) || (r_count != '0);
    assign overflow   = r_ovf;
    assign fifo_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_byte[7:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_sh     <= '0;
            r_rd_ptr <= '0;
            r_tx     <= 1'b1;
        end else begin
            // Line is registered from the current state, so it trails the FSM by one cycle.
            r_tx <= (r_state == S_START) ? 1'b0 :
                    (r_state == S_DATA)  ? r_sh[0] : 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    if (w_pop) begin
                        r_sh     <= r_mem[r_rd_ptr];
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        r_sh   <= {1'b0, r_sh[7:1]};
                        if (r_bit == 3'd7) begin
                            r_bit   <= '0;
                            r_state <= S_STOP;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_baud  <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
